wb_ram_arb: RTL and testbench
=============================

Name: wb_ram_arb

Overview:
- Two-master to one-slave Wishbone arbiter that shares a single-ported wb_ram between the CPU instruction bus (m0) and data bus (m1).
- Grants the slave to one master per bus cycle and holds the grant while that master keeps cyc asserted.
- Routes address, data and control to the slave; returns read data and ack only to the granted master.
- Sits between or1200 IWB/DWB and the on-chip RAM in the SOPC.

Parameters:
- AW, 32, address width of masters and slave.
- DW, 32, data width; select width is DW/8.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset, synchronous, active-high.
- m0_cyc_i, m1_cyc_i  input  1  master bus cycle request.
- m0_stb_i, m1_stb_i  input  1  master strobe.
- m0_we_i, m1_we_i  input  1  master write enable.
- m0_sel_i, m1_sel_i  input  DW/8  master byte selects.
- m0_adr_i, m1_adr_i  input  AW  master byte address.
- m0_dat_i, m1_dat_i  input  DW  master write data.
- m0_dat_o, m1_dat_o  output  DW  read data; both driven from s_dat_i.
- m0_ack_o, m1_ack_o  output  1  ack; only the granted master sees it.
- s_cyc_o, s_stb_o, s_we_o  output  1  slave control.
- s_sel_o  output  DW/8  slave byte selects.
- s_adr_o  output  AW  slave address.
- s_dat_o  output  DW  slave write data.
- s_dat_i  input  DW  slave read data.
- s_ack_i  input  1  slave ack.

Behaviour:
- State register, one-hot or encoded: IDLE, GNT0, GNT1. Reset: IDLE, last_grant=1. All arbitration state updates on the rising edge of wb_clk_i.
- IDLE:
  - m0_cyc_i only -> GNT0.
  - m1_cyc_i only -> GNT1.
  - Both -> fixed priority: GNT0 (see optional feature).
  - Neither -> stay IDLE.
- GNTn: stay while mn_cyc_i=1. When mn_cyc_i=0, go directly to the other master's GNT state if its cyc=1, else go to IDLE. No idle bubble on handover.
- Arbitration latency: 1 cycle from cyc rise in IDLE to s_cyc_o/s_stb_o.
- Slave outputs are a combinational mux selected by state:
  - IDLE: s_cyc_o=s_stb_o=s_we_o=0; s_sel_o, s_adr_o, s_dat_o=0.
  - GNTn: s_cyc_o=mn_cyc_i, s_stb_o=mn_stb_i; we, sel, adr and dat from master n.
- mn_ack_o = s_ack_i & (state==GNTn). Non-granted master ack is always 0. m0_dat_o = m1_dat_o = s_dat_i.
- Slave acks one cycle after stb; write commit happens in the ack cycle. A grant therefore must not change while s_ack_i=1: transition out of GNTn is suppressed in any cycle with s_ack_i=1.
- A master dropping cyc without ever receiving ack is legal (abort). Grant releases the next cycle.
- Reset asserted mid-transfer: next edge forces IDLE. s_cyc_o/s_stb_o are 0 from that edge onward; any pending s_ack_i is masked because the state is IDLE.
- A stray s_ack_i in IDLE is ignored; no master ack is produced.
- last_grant updates to n on every entry into GNTn.

Optional Feature:
- Macro: WB_RAM_ARB_RR_EN.
- Defined: simultaneous requests in IDLE, or a handover contention, are resolved round-robin. The master that is not last_grant wins.
- Undefined: fixed priority, m0 always wins. last_grant is still maintained but unused.

Test Plan:
- Reset, then m0 read at adr 0x10 with RAM[4]=0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses once with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- m1 write adr 0x20, sel=4'b0011, dat=0x12345678, then m1 read -> RAM[8] low half =0x5678, upper bytes unchanged; all acks go to m1 only.
- m0 and m1 assert cyc on the same edge:
  - Fixed priority: m0 is granted first; m1 is granted the cycle after m0_cyc_i falls, with no IDLE gap.
  - With WB_RAM_ARB_RR_EN after a prior m0 grant: m1 is granted first.
- m0 holds cyc for 3 back-to-back reads while m1 requests -> m1 stays ungranted (m1_ack_o=0) until m0 releases; then it completes.
- wb_rst_i pulsed the cycle after m1 stb (ack pending) -> state IDLE; s_cyc_o=0 next cycle; m1_ack_o never asserts.
- m0 aborts (cyc drops before ack) -> grant returns to IDLE next cycle; RAM contents unchanged.

Source files
------------

// File: rtl/wb_ram_arb.sv
// rtl/wb_ram_arb.sv - two-master Wishbone arbiter sharing one wb_ram slave
// Optional round-robin contention resolution: define WB_RAM_ARB_RR_EN.
module wb_ram_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   pick1;

`ifdef WB_RAM_ARB_RR_EN
   assign pick1 = ~last_grant;
`else
   logic unused_last_grant;
   assign pick1             = 1'b0;
   assign unused_last_grant = last_grant;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt == GNT0 && state != GNT0)
            last_grant <= 1'b0;
         else if (state_nxt == GNT1 && state != GNT1)
            last_grant <= 1'b1;
      end
   end

   // A grant never moves while the slave is acking: the write commits in that cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_nxt = pick1 ? GNT1 : GNT0;
            else if (m0_cyc_i)
               state_nxt = GNT0;
            else if (m1_cyc_i)
               state_nxt = GNT1;
         end
         GNT0: begin
            if (!s_ack_i && !m0_cyc_i)
               state_nxt = m1_cyc_i ? GNT1 : IDLE;
         end
         GNT1: begin
            if (!s_ack_i && !m1_cyc_i)
               state_nxt = m0_cyc_i ? GNT0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      case (state)
         GNT0: begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
         end
         GNT1: begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
         end
         default: ;
      endcase
   end

   assign m0_ack_o = s_ack_i & (state == GNT0);
   assign m1_ack_o = s_ack_i & (state == GNT1);
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arb.sv
// tb/tb_wb_ram_arb.sv - randomized self-checking bench for wb_ram_arb
// Bench-side RAM slave plus an ownership/memory reference model.
module tb_wb_ram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        mcyc[2], mstb[2], mwe[2];
   logic [3:0]  msel[2];
   logic [31:0] madr[2], mdat[2];
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m1_ack_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic        s_ack = 1'b0;
   logic [31:0] ram[64];
   logic [31:0] ref_mem[64];
   logic [31:0] last_rd[2];
   int          n_chk = 0, n_err = 0;
   int          own = -1, lg = 1;
   int          cyc_cnt = 0;
   bit          mon_en = 1'b0;
   int          ack_order[$];
   int          ack_cyc[$];

   always #5 clk = ~clk;

   wb_ram_arb #(.AW(32), .DW(32)) dut (
      .wb_clk_i(clk),      .wb_rst_i(rst),
      .m0_cyc_i(mcyc[0]),  .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
      .m0_sel_i(msel[0]),  .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_cyc_i(mcyc[1]),  .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
      .m1_sel_i(msel[1]),  .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_cyc_o(s_cyc_o),   .s_stb_o(s_stb_o),  .s_we_o(s_we_o),
      .s_sel_o(s_sel_o),   .s_adr_o(s_adr_o),  .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i),   .s_ack_i(s_ack)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hA5000000 ^ (32'(i) * 32'h00010307);
   endfunction

   // Who owns the slave after the next edge, straight from the arbitration rules.
   function automatic int next_owner(input int o, input logic c0, input logic c1,
                                     input logic ack, input int l);
      if (o >= 0) begin
         if (ack || (o == 0 ? c0 : c1)) return o;
         return (o == 0 ? c1 : c0) ? 1 - o : -1;
      end
      if (c0 && c1) begin
`ifdef WB_RAM_ARB_RR_EN
         return 1 - l;
`else
         return 0;
`endif
      end
      if (c0) return 0;
      if (c1) return 1;
      return -1;
   endfunction

   function automatic logic [127:0] bus_of(input int o);
      if (o < 0) return '0;
      return {57'd0, mcyc[o], mstb[o], mwe[o], msel[o], madr[o], mdat[o]};
   endfunction

   // wb_ram behaviour: ack one cycle after stb, write lands in the ack cycle
   assign s_dat_i = ram[s_adr_o[7:2]];
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      s_ack   <= s_cyc_o & s_stb_o & ~s_ack;
      if (load) begin
         for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      end else if (s_ack & s_cyc_o & s_stb_o & s_we_o) begin
         for (int b = 0; b < 4; b++)
            if (s_sel_o[b]) ram[s_adr_o[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         own <= -1;
         lg  <= 1;
      end else begin
         own <= next_owner(own, mcyc[0], mcyc[1], s_ack, lg);
         if (next_owner(own, mcyc[0], mcyc[1], s_ack, lg) >= 0 &&
             next_owner(own, mcyc[0], mcyc[1], s_ack, lg) != own)
            lg <= next_owner(own, mcyc[0], mcyc[1], s_ack, lg);
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("s_bus", {57'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, bus_of(own));
         chk("acks", {126'd0, m0_ack_o, m1_ack_o}, {126'd0, s_ack && own == 0, s_ack && own == 1});
      end
   end

   task automatic m_burst(input int m, input int n, input bit rnd, input logic we_d,
                          input logic [31:0] adr_d, input logic [3:0] sel_d,
                          input logic [31:0] dat_d);
      for (int k = 0; k < n; k++) begin
         logic        we;
         logic [3:0]  sel;
         logic [31:0] adr, dat, rd;
         bit          got;
         int          idx;
         if (rnd) begin
            we  = 1'($urandom_range(0, 1));
            adr = 32'($urandom_range(0, 15)) << 2;
            sel = 4'($urandom_range(1, 15));
            dat = $urandom;
         end else begin
            we = we_d; adr = adr_d; sel = sel_d; dat = dat_d;
         end
         mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we;
         msel[m] = sel;  madr[m] = adr;  mdat[m] = dat;
         got = 1'b0;
         for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack_o : m1_ack_o;
         end
         chk("ack_wait", {127'd0, got}, 128'd1);
         if (!got) begin
            mcyc[m] = 1'b0; mstb[m] = 1'b0;
            return;
         end
         ack_order.push_back(m);
         ack_cyc.push_back(cyc_cnt);
         idx = int'(adr[7:2]);
         rd  = (m == 0) ? m0_dat_o : m1_dat_o;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
         end else begin
            last_rd[m] = rd;
            chk("rdata", {96'd0, rd}, {96'd0, ref_mem[idx]});
         end
         @(posedge clk); #1;
      end
      mcyc[m] = 1'b0; mstb[m] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w8, exp8;
      int          first_exp;
      for (int m = 0; m < 2; m++) begin
         mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
         msel[m] = '0;   madr[m] = '0;   mdat[m] = '0;
      end
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      rst = 1'b1; load = 1'b1;
      repeat (3) @(posedge clk);
      #1 load = 1'b0; rst = 1'b0; mon_en = 1'b1;
      @(negedge clk);
      chk("rst_idle", {126'd0, s_cyc_o, s_stb_o}, 128'd0);
      @(posedge clk); #1;

      // m0 read of RAM[4] with arbitration latency check
      fork
         m_burst(0, 1, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
         begin
            @(negedge clk); chk("lat_before", {127'd0, s_cyc_o}, 128'd0);
            @(negedge clk); chk("lat_after", {127'd0, s_cyc_o}, 128'd1);
         end
      join
      chk("t1_rdata", {96'd0, last_rd[0]}, {96'd0, 32'hDEADBEEF});

      // m1 partial write then read back
      ack_order.delete();
      m_burst(1, 1, 1'b0, 1'b1, 32'h20, 4'b0011, 32'h12345678);
      m_burst(1, 1, 1'b0, 1'b0, 32'h20, 4'hF, 32'h0);
      w8   = init_word(8);
      exp8 = {w8[31:16], 16'h5678};
      chk("t2_rdata", {96'd0, last_rd[1]}, {96'd0, exp8});
      chk("t2_order", {126'd0, ack_order.size() == 2, ack_order[0] == 1 && ack_order[1] == 1}, 128'd3);

      // simultaneous request after an m0 grant
      m_burst(0, 1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
      repeat (2) @(posedge clk); #1;
      ack_order.delete(); ack_cyc.delete();
`ifdef WB_RAM_ARB_RR_EN
      first_exp = 1;
`else
      first_exp = 0;
`endif
      fork
         m_burst(0, 2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
         m_burst(1, 2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      join
      chk("t3_first", 128'(ack_order[0]), 128'(first_exp));
      chk("t3_hold", 128'(ack_order[1]), 128'(first_exp));
      chk("t3_handover", 128'(ack_cyc[2] - ack_cyc[1]), 128'd3);

      // m0 holds three reads while m1 waits
      ack_order.delete();
      fork
         m_burst(0, 3, 1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
         begin
            @(posedge clk); #1;
            m_burst(1, 1, 1'b0, 1'b0, 32'h20, 4'hF, 32'h0);
         end
      join
      chk("t4_order", {124'd0, ack_order[0] == 0, ack_order[1] == 0,
                       ack_order[2] == 0, ack_order[3] == 1}, 128'hF);

      // reset while m1 write ack is pending
      repeat (2) @(posedge clk); #1;
      mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1;
      msel[1] = 4'hF; madr[1] = 32'h30; mdat[1] = 32'hCAFEF00D;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t5_scyc", {127'd0, s_cyc_o}, 128'd0);
         chk("t5_m1ack", {127'd0, m1_ack_o}, 128'd0);
      end
      chk("t5_ram", {96'd0, ram[12]}, {96'd0, ref_mem[12]});
      @(posedge clk); #1;

      // m0 abort before ack
      mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b1;
      msel[0] = 4'hF; madr[0] = 32'h14; mdat[0] = 32'h11111111;
      @(posedge clk); #1 mcyc[0] = 1'b0; mstb[0] = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t6_idle", {96'd0, s_adr_o}, 128'd0);
      repeat (3) @(posedge clk); #1;
      chk("t6_ram", {96'd0, ram[5]}, {96'd0, ref_mem[5]});

      // randomized contention rounds
      for (int r = 0; r < 40; r++) begin
         fork
            begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1 m_burst(0, $urandom_range(0, 3), 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
            end
            begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1 m_burst(1, $urandom_range(0, 3), 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
            end
         join
      end
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 16; i++) chk("mem_final", {96'd0, ram[i]}, {96'd0, ref_mem[i]});

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
